tty_ctrl: RTL and testbench

TTY_CTRL -- requirements
Module: tty_ctrl

---
 rtl/tty_pkg.sv | 28 ++
 rtl/tty_if.sv | 22 ++
 rtl/tty_rx_fifo.sv | 62 ++++++
 rtl/tty_ctrl.sv | 144 ++++++++++++++
 tb/tb_tty_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tty_pkg.sv
// Shared definitions for the teleprinter/keyboard IOT controller:
// transmit FSM states, IOT op-codes and the optional receive FIFO depth.
package tty_pkg;

    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_SEND,
        TX_START,
        TX_DONE
    } tx_state_e;

    localparam logic [2:0] OP_KCF = 3'd0;
    localparam logic [2:0] OP_KSF = 3'd1;
    localparam logic [2:0] OP_KCC = 3'd2;
    localparam logic [2:0] OP_KRS = 3'd4;
    localparam logic [2:0] OP_KIE = 3'd5;
    localparam logic [2:0] OP_KRB = 3'd6;

    localparam logic [2:0] OP_TFL = 3'd0;
    localparam logic [2:0] OP_TSF = 3'd1;
    localparam logic [2:0] OP_TCF = 3'd2;
    localparam logic [2:0] OP_TPC = 3'd4;
    localparam logic [2:0] OP_TLS = 3'd6;

endpackage

// File: rtl/tty_if.sv
// CPU-side IOT bus between the processor (master) and the TTY controller (slave).
interface tty_if;
    logic        iot_strobe;
    logic [5:0]  iot_dev;
    logic [2:0]  iot_op;
    logic [11:0] ac_in;
    logic [11:0] ac_out;
    logic        ac_or;
    logic        ac_clr;
    logic        skip;
    logic        irq;

    modport master (
        output iot_strobe, iot_dev, iot_op, ac_in,
        input  ac_out, ac_or, ac_clr, skip, irq
    );

    modport slave (
        input  iot_strobe, iot_dev, iot_op, ac_in,
        output ac_out, ac_or, ac_clr, skip, irq
    );
endinterface

// File: rtl/tty_rx_fifo.sv
// Receive byte buffer; DEPTH=1 behaves as a single holding register.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module tty_rx_fifo
    import tty_pkg::*;
#(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overrun_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovr_q;
    logic              pop_ok, push_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);
    assign head_o    = empty_o ? '0 : mem_q[rd_q];
    assign overrun_o = ovr_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (pop_ok)  rd_q <= next_ptr(rd_q);
            if (push_ok) wr_q <= next_ptr(wr_q);
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
            ovr_q <= push_i && full_o && !pop_ok;
        end
    end
endmodule

// File: rtl/tty_ctrl.sv
// Keyboard/teleprinter IOT controller. Define TTY_RX_FIFO_EN for a 4-entry
// receive FIFO; otherwise the keyboard buffer is a single byte register.
module tty_ctrl
    import tty_pkg::*;
#(
    parameter logic [5:0] KBD_DEV = 6'o03,
    parameter logic [5:0] TTY_DEV = 6'o04
) (
    input  logic       clk,
    input  logic       nrst,
    tty_if.slave       bus,
    input  logic       rx_load,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_overrun,
    output logic       tx_load,
    output logic [7:0] tx_data,
    input  logic       tx_ready
);
`ifdef TTY_RX_FIFO_EN
    localparam int unsigned RX_DEPTH = FIFO_DEPTH;
`else
    localparam int unsigned RX_DEPTH = 1;
`endif

    logic       kbd_hit, tty_hit;
    logic       pop_d, ac_or_d, ac_clr_d, skip_d, print_d, tset_d, tclr_d, ie_wr_d;
    logic       ac_or_q, ac_clr_q, skip_q, irq_q, ie_q, tty_flag_q;
    logic [7:0] ac_out_q, head;
    logic       rx_empty, rx_full, kbd_flag, done_exit;
    tx_state_e  state_q;
    logic       tx_load_q;
    logic [7:0] tx_data_q;
    logic       unused_ac;

    assign kbd_hit   = bus.iot_strobe && (bus.iot_dev == KBD_DEV);
    assign tty_hit   = bus.iot_strobe && (bus.iot_dev == TTY_DEV);
    assign kbd_flag  = !rx_empty;
    assign done_exit = (state_q == TX_DONE) && tx_ready;
    assign unused_ac = ^bus.ac_in[11:8];

    tty_rx_fifo #(.DEPTH(RX_DEPTH), .DATA_W(8)) u_rx_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push_i    (rx_load),
        .data_i    (rx_data),
        .pop_i     (pop_d),
        .head_o    (head),
        .empty_o   (rx_empty),
        .full_o    (rx_full),
        .overrun_o (rx_overrun)
    );

    always_comb begin
        pop_d    = 1'b0;
        ac_or_d  = 1'b0;
        ac_clr_d = 1'b0;
        skip_d   = 1'b0;
        print_d  = 1'b0;
        tset_d   = 1'b0;
        tclr_d   = 1'b0;
        ie_wr_d  = 1'b0;
        if (kbd_hit) begin
            case (bus.iot_op)
                OP_KCF: pop_d = 1'b1;
                OP_KSF: skip_d = kbd_flag;
                OP_KCC: begin ac_clr_d = 1'b1; pop_d = 1'b1; end
                OP_KRS: ac_or_d = 1'b1;
                OP_KIE: ie_wr_d = 1'b1;
                OP_KRB: begin ac_clr_d = 1'b1; ac_or_d = 1'b1; pop_d = 1'b1; end
                default: ;
            endcase
        end
        if (tty_hit) begin
            case (bus.iot_op)
                OP_TFL: tset_d = 1'b1;
                OP_TSF: skip_d = tty_flag_q;
                OP_TCF: tclr_d = 1'b1;
                OP_TPC: print_d = 1'b1;
                OP_TLS: begin tclr_d = 1'b1; print_d = 1'b1; end
                default: ;
            endcase
        end
    end

    // Print requests arriving while a byte is in flight are simply ignored.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= TX_IDLE;
            tx_load_q <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_load_q <= 1'b0;
            case (state_q)
                TX_IDLE:  if (print_d) begin
                              tx_data_q <= bus.ac_in[7:0];
                              state_q   <= TX_WAIT;
                          end
                TX_WAIT:  if (tx_ready) begin
                              tx_load_q <= 1'b1;
                              state_q   <= TX_SEND;
                          end
                TX_SEND:  state_q <= TX_START;
                TX_START: if (!tx_ready) state_q <= TX_DONE;
                TX_DONE:  if (tx_ready) state_q <= TX_IDLE;
                default:  state_q <= TX_IDLE;
            endcase
        end
    end

    // ac_out is captured before a same-cycle pop so the CPU ORs in the popped byte.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ac_or_q    <= 1'b0;
            ac_clr_q   <= 1'b0;
            skip_q     <= 1'b0;
            irq_q      <= 1'b0;
            ie_q       <= 1'b1;
            tty_flag_q <= 1'b0;
            ac_out_q   <= '0;
        end else begin
            ac_or_q  <= ac_or_d;
            ac_clr_q <= ac_clr_d;
            skip_q   <= skip_d;
            irq_q    <= ie_q & (kbd_flag | tty_flag_q);
            ac_out_q <= head;
            if (ie_wr_d) ie_q <= bus.ac_in[0];
            if (tclr_d) begin
                tty_flag_q <= 1'b0;
            end else if (tset_d || done_exit) begin
                tty_flag_q <= 1'b1;
            end
        end
    end

    assign bus.ac_out = {4'b0000, ac_out_q};
    assign bus.ac_or  = ac_or_q;
    assign bus.ac_clr = ac_clr_q;
    assign bus.skip   = skip_q;
    assign bus.irq    = irq_q;
    assign rx_ready   = !rx_full;
    assign tx_load    = tx_load_q;
    assign tx_data    = tx_data_q;
endmodule

// File: tb/tb_tty_ctrl.sv
// Bench for tty_ctrl: directed vector table, multi-cycle print/overrun/reset
// sequences, then random IOT/receive traffic against a queue-based model.
module tb_tty_ctrl;
    localparam logic [5:0] KDEV = 6'o03;
    localparam logic [5:0] TDEV = 6'o04;
`ifdef TTY_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx_load;
    logic [7:0] rx_data;
    logic       rx_ready, rx_overrun, tx_load;
    logic [7:0] tx_data;
    logic       tx_ready;
    int         errors = 0;
    int         checks = 0;

    tty_if bus ();

    tty_ctrl #(.KBD_DEV(KDEV), .TTY_DEV(TDEV)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .bus        (bus),
        .rx_load    (rx_load),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [5:0]  dev;
        logic [2:0]  op;
        logic [11:0] ac;
        logic        rl;
        logic [7:0]  rd;
        logic        e_or;
        logic        e_clr;
        logic        e_skip;
        logic        e_irq;
        logic [11:0] e_ac;
    } vec_t;

    vec_t tbl [22];

    logic [7:0] mq [$];
    bit         mflag;
    bit         mie;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [5:0] d, input logic [2:0] o,
                         input logic [11:0] a, input logic rl, input logic [7:0] rd);
        bus.iot_strobe = s;
        bus.iot_dev    = d;
        bus.iot_op     = o;
        bus.ac_in      = a;
        rx_load        = rl;
        rx_data        = rd;
    endtask

    task automatic idle_in();
        drive(1'b0, 6'o00, 3'd0, 12'h000, 1'b0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_step(input logic [5:0] d, input logic [2:0] o, input logic [11:0] a);
        drive(1'b1, d, o, a, 1'b0, 8'h00);
        tick();
        idle_in();
    endtask

    task automatic load_step(input logic [7:0] b);
        drive(1'b0, 6'o00, 3'd0, 12'h000, 1'b1, b);
        tick();
        idle_in();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ac_or"},   32'(bus.ac_or),   32'd0);
        chk({tag, "_ac_clr"},  32'(bus.ac_clr),  32'd0);
        chk({tag, "_skip"},    32'(bus.skip),    32'd0);
        chk({tag, "_irq"},     32'(bus.irq),     32'd0);
        chk({tag, "_tx_load"}, 32'(tx_load),     32'd0);
        chk({tag, "_rx_ovr"},  32'(rx_overrun),  32'd0);
        chk({tag, "_rx_rdy"},  32'(rx_ready),    32'd1);
        chk({tag, "_tx_data"}, 32'(tx_data),     32'd0);
        chk({tag, "_ac_out"},  32'(bus.ac_out),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [7:0]  got;
        bit          seen;
        logic        s, rl, hit_k, hit_t, pop, popped, full;
        logic [5:0]  d;
        logic [2:0]  o;
        logic [11:0] a;
        logic [7:0]  rd, head;
        logic        e_or, e_clr, e_skip, e_irq, e_ovr, e_rdy;
        logic [17:0] exp_v, act_v;

        tbl[0]  = '{1'b0, 6'o00, 3'd0, 12'h000, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[1]  = '{1'b0, 6'o00, 3'd0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0C1};
        tbl[2]  = '{1'b1, 6'o03, 3'd1, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0C1};
        tbl[3]  = '{1'b1, 6'o03, 3'd6, 12'h000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0C1};
        tbl[4]  = '{1'b1, 6'o03, 3'd1, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[5]  = '{1'b1, 6'o04, 3'd0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[6]  = '{1'b1, 6'o04, 3'd1, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[7]  = '{1'b1, 6'o04, 3'd2, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[8]  = '{1'b1, 6'o04, 3'd1, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[9]  = '{1'b0, 6'o00, 3'd0, 12'h000, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[10] = '{1'b1, 6'o05, 3'd1, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 12'h05A};
        tbl[11] = '{1'b1, 6'o03, 3'd4, 12'h000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h05A};
        tbl[12] = '{1'b1, 6'o03, 3'd3, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 12'h05A};
        tbl[13] = '{1'b1, 6'o03, 3'd2, 12'h000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 12'h05A};
        tbl[14] = '{1'b0, 6'o00, 3'd0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[15] = '{1'b1, 6'o03, 3'd5, 12'hFFE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[16] = '{1'b1, 6'o04, 3'd0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[17] = '{1'b0, 6'o00, 3'd0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[18] = '{1'b1, 6'o03, 3'd5, 12'h001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[19] = '{1'b0, 6'o00, 3'd0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[20] = '{1'b1, 6'o04, 3'd2, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[21] = '{1'b0, 6'o00, 3'd0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};

        nrst = 1'b0;
        tx_ready = 1'b0;
        idle_in();
        tick();
        tick();
        check_reset("por");
        nrst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].s, tbl[i].dev, tbl[i].op, tbl[i].ac, tbl[i].rl, tbl[i].rd);
            tick();
            idle_in();
            chk($sformatf("vec%0d_ac_or", i),  32'(bus.ac_or),  32'(tbl[i].e_or));
            chk($sformatf("vec%0d_ac_clr", i), 32'(bus.ac_clr), 32'(tbl[i].e_clr));
            chk($sformatf("vec%0d_skip", i),   32'(bus.skip),   32'(tbl[i].e_skip));
            chk($sformatf("vec%0d_irq", i),    32'(bus.irq),    32'(tbl[i].e_irq));
            chk($sformatf("vec%0d_ac_out", i), 32'(bus.ac_out), 32'(tbl[i].e_ac));
        end

        for (int i = 0; i < DEPTH; i++) load_step(8'(8'h10 + i));
        chk("full_rx_ready", 32'(rx_ready), 32'd0);
        load_step(8'h41);
        chk("ovr_pulse", 32'(rx_overrun), 32'd1);
        tick();
        chk("ovr_one_cycle", 32'(rx_overrun), 32'd0);
        chk("ovr_head_kept", 32'(bus.ac_out), 32'h010);
        drive(1'b1, KDEV, 3'd0, 12'h000, 1'b1, 8'h41);
        tick();
        idle_in();
        chk("pop_load_no_ovr", 32'(rx_overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            op_step(KDEV, 3'd6, 12'h000);
            chk($sformatf("drain%0d", i), 32'(bus.ac_out),
                (i == DEPTH - 1) ? 32'h041 : 32'(32'h11 + i));
        end
        chk("drained_rx_ready", 32'(rx_ready), 32'd1);

        tx_ready = 1'b1;
        op_step(TDEV, 3'd6, 12'h0D7);
        n = 0;
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) drive(1'b1, TDEV, 3'd4, 12'h055, 1'b0, 8'h00);
            tick();
            idle_in();
            if (tx_load) begin
                n++;
                got = tx_data;
            end
        end
        chk("tls_load_count", 32'(n), 32'd1);
        chk("tls_data", 32'(got), 32'h0D7);
        chk("busy_drop_data", 32'(tx_data), 32'h0D7);
        tx_ready = 1'b0;
        tick();
        tick();
        chk("irq_before_done", 32'(bus.irq), 32'd0);
        tx_ready = 1'b1;
        tick();
        tick();
        chk("done_irq", 32'(bus.irq), 32'd1);
        op_step(TDEV, 3'd1, 12'h000);
        chk("done_tsf_skip", 32'(bus.skip), 32'd1);
        op_step(TDEV, 3'd2, 12'h000);

        op_step(TDEV, 3'd4, 12'h03A);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (tx_load) seen = 1'b1;
        end
        chk("tpc_load_seen", 32'(seen), 32'd1);
        chk("tpc_data", 32'(tx_data), 32'h03A);
        tx_ready = 1'b0;
        tick();
        tick();
        drive(1'b1, TDEV, 3'd2, 12'h000, 1'b0, 8'h00);
        tx_ready = 1'b1;
        tick();
        idle_in();
        tick();
        chk("clr_wins_irq", 32'(bus.irq), 32'd0);
        op_step(TDEV, 3'd1, 12'h000);
        chk("clr_wins_skip", 32'(bus.skip), 32'd0);

        load_step(8'h77);
        op_step(TDEV, 3'd0, 12'h000);
        op_step(TDEV, 3'd4, 12'h0A5);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (tx_load) seen = 1'b1;
        end
        chk("rst_tpc_load_seen", 32'(seen), 32'd1);
        tick();
        chk("pre_rst_irq", 32'(bus.irq), 32'd1);
        #2 nrst = 1'b0;
        #1 check_reset("mid");
        tick();
        nrst = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tx_ready = i[0];
            tick();
            if (tx_load) n++;
        end
        chk("no_load_after_rst", 32'(n), 32'd0);
        op_step(TDEV, 3'd1, 12'h000);
        chk("rst_tty_flag", 32'(bus.skip), 32'd0);

        tx_ready = 1'b0;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        mq.delete();
        mflag = 1'b0;
        mie = 1'b1;
        for (int c = 0; c < 400; c++) begin
            s = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 2))
                0: d = KDEV;
                1: d = TDEV;
                default: d = 6'(6'o10 + $urandom_range(0, 7));
            endcase
            o = 3'($urandom_range(0, 7));
            if (d == TDEV && (o == 3'd4 || o == 3'd6)) o = 3'd1;
            a = 12'($urandom());
            rl = ($urandom_range(0, 9) < 4);
            rd = 8'($urandom());

            hit_k  = s && (d == KDEV);
            hit_t  = s && (d == TDEV);
            head   = (mq.size() != 0) ? mq[0] : 8'h00;
            e_irq  = mie && ((mq.size() != 0) || mflag);
            e_or   = hit_k && (o == 3'd4 || o == 3'd6);
            e_clr  = hit_k && (o == 3'd2 || o == 3'd6);
            pop    = hit_k && (o == 3'd0 || o == 3'd2 || o == 3'd6);
            e_skip = (hit_k && o == 3'd1 && mq.size() != 0) || (hit_t && o == 3'd1 && mflag);
            full   = (mq.size() == DEPTH);
            popped = pop && (mq.size() != 0);
            if (popped) void'(mq.pop_front());
            e_ovr = 1'b0;
            if (rl) begin
                if (full && !popped) e_ovr = 1'b1;
                else mq.push_back(rd);
            end
            if (hit_k && o == 3'd5) mie = a[0];
            if (hit_t && o == 3'd0) mflag = 1'b1;
            if (hit_t && o == 3'd2) mflag = 1'b0;
            e_rdy = (mq.size() < DEPTH);

            drive(s, d, o, a, rl, rd);
            tick();
            exp_v = {e_or, e_clr, e_skip, e_irq, e_ovr, e_rdy, 4'h0, head};
            act_v = {bus.ac_or, bus.ac_clr, bus.skip, bus.irq, rx_overrun, rx_ready, bus.ac_out};
            chk($sformatf("rand%0d", c), 32'(act_v), 32'(exp_v));
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
